iq_stream_tx: RTL and testbench

Output stage placed directly after the top-level DUT output registers. It consumes the registered 9-bit I/Q stream (`in_en` plus `in_data_i`/`in_data_q`) and the `in_done` end-of-block pulse. It re-emits the samples as an 18-bit valid/ready stream with a correct per-frame `m_last` marker. A one-entry holdback register plus a synchronous FIFO absorb downstream backpressure, since the upstream pipeline cannot stall.

---
 rtl/iq_stream_pkg.sv | 10 +
 rtl/iq_sync_fifo.sv | 44 ++++
 rtl/iq_stream_tx.sv | 90 +++++++++
 tb/tb_iq_stream_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/iq_stream_pkg.sv
// iq_stream_pkg: shared widths and the FIFO entry layout for the I/Q output stage
package iq_stream_pkg;
  localparam int SAMPLE_W = 9;
  localparam int WORD_W = 18;
  typedef struct packed {
    logic                last;
    logic [SAMPLE_W-1:0] q;
    logic [SAMPLE_W-1:0] i;
  } entry_t;
endpackage

// File: rtl/iq_sync_fifo.sv
// iq_sync_fifo: generic single-clock FIFO with combinational head read and occupancy count
module iq_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_wr, do_rd;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign level   = cnt_q;
  assign do_rd   = rd_en & ~empty;
  // a write into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
  // storage array, no reset needed since empty entries are never presented
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/iq_stream_tx.sv
// iq_stream_tx: I/Q sample stream to valid/ready with frame last marker; IQ_STREAM_TX_DROP_CNT_EN adds drop_cnt
module iq_stream_tx
  import iq_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic signed [SAMPLE_W-1:0]  in_data_i,
  input  logic signed [SAMPLE_W-1:0]  in_data_q,
  input  logic                        in_done,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WORD_W-1:0]           m_data,
  output logic                        m_last,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
`ifdef IQ_STREAM_TX_DROP_CNT_EN
  output logic [CNT_W-1:0]            drop_cnt,
`endif
  output logic [CNT_W-1:0]            frame_cnt
);
  logic              hold_vld_q, hold_vld_d;
  logic              hold_last_q, hold_last_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              push, push_last, pop, drop, empty, full;
  entry_t            wr_entry, head;
  assign push      = hold_vld_q & (in_en | in_done | hold_last_q);
  assign push_last = hold_last_q | (in_done & ~in_en);
  assign wr_entry  = {push_last, hold_data_q};
  assign m_valid   = ~empty;
  assign pop       = m_valid & m_ready;
  assign drop      = push & full & ~pop;
  assign m_data    = m_valid ? {head.q, head.i} : '0;
  assign m_last    = m_valid & head.last;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

  iq_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  // holdback: keep the newest sample until its last status is known
  always_comb begin
    hold_vld_d  = in_en ? 1'b1 : push ? 1'b0 : hold_vld_q;
    hold_last_d = in_en ? in_done : push ? 1'b0 : hold_last_q;
    hold_data_d = in_en ? {in_data_q, in_data_i} : hold_data_q;
    overflow_d  = overflow_q | drop;
    frame_cnt_d = frame_cnt_q + CNT_W'(pop & head.last);
  end

  // state registers; reset discards anything held mid-frame
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_last_q <= hold_last_d;
      hold_data_q <= hold_data_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef IQ_STREAM_TX_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;
  // saturating count of words lost to a full FIFO
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_iq_stream_tx.sv
// tb_iq_stream_tx: directed table and sequence checks for iq_stream_tx; IQ_STREAM_TX_DROP_CNT_EN checks drop_cnt
module tb_iq_stream_tx;
  logic        clk = 0, rst = 1, in_en = 0, in_done = 0, m_ready = 1;
  logic [8:0]  in_data_i = '0, in_data_q = '0;
  logic        m_valid, m_last, overflow;
  logic [17:0] m_data;
  logic [4:0]  level;
  logic [15:0] frame_cnt;
`ifdef IQ_STREAM_TX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int errors = 0, checks = 0;
  logic [18:0] got[$];
  logic        stab_en = 0, prev_stall = 0;
  logic [18:0] prev_w = '0;

  iq_stream_tx dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data_i(in_data_i), .in_data_q(in_data_q),
    .in_done(in_done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .level(level), .overflow(overflow),
`ifdef IQ_STREAM_TX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    int          i;
    int          q;
    logic        done;
    logic        vld;
    logic [18:0] word;
    logic [4:0]  lvl;
    int          fcnt;
  } vec_t;
  vec_t tv[15];

  function automatic logic [18:0] wd(input logic last, input int q, input int i);
    return {last, 9'(q), 9'(i)};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input logic en, input int i, input int q, input logic done);
    in_en = en; in_data_i = 9'(i); in_data_q = 9'(q); in_done = done;
    @(posedge clk); #1;
    in_en = 0; in_done = 0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (got.size() < n && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("word_count_timeout", got.size(), n);
  endtask

  always @(posedge clk) if (!rst && m_valid && m_ready) got.push_back({m_last, m_data});

  always @(negedge clk) begin
    if (!stab_en) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall_stable", {13'd0, m_last, m_data}, {13'd0, prev_w});
      prev_stall = m_valid & ~m_ready;
      prev_w = {m_last, m_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b1, 1, -1, 1'b0, 1'b0, 19'h0, 5'd0, 0};
    tv[1]  = '{1'b1, 2, -2, 1'b0, 1'b1, wd(0, -1, 1), 5'd1, 0};
    tv[2]  = '{1'b1, 3, -3, 1'b0, 1'b1, wd(0, -2, 2), 5'd1, 0};
    tv[3]  = '{1'b1, 4, -4, 1'b0, 1'b1, wd(0, -3, 3), 5'd1, 0};
    tv[4]  = '{1'b0, 0, 0, 1'b0, 1'b0, 19'h0, 5'd0, 0};
    tv[5]  = '{1'b0, 0, 0, 1'b1, 1'b1, 19'h7F804, 5'd1, 0};
    tv[6]  = '{1'b0, 0, 0, 1'b0, 1'b0, 19'h0, 5'd0, 1};
    tv[7]  = '{1'b1, 10, 20, 1'b0, 1'b0, 19'h0, 5'd0, 1};
    tv[8]  = '{1'b1, 11, 21, 1'b0, 1'b1, wd(0, 20, 10), 5'd1, 1};
    tv[9]  = '{1'b1, 12, 22, 1'b1, 1'b1, wd(0, 21, 11), 5'd1, 1};
    tv[10] = '{1'b0, 0, 0, 1'b0, 1'b1, wd(1, 22, 12), 5'd1, 1};
    tv[11] = '{1'b1, 30, 31, 1'b0, 1'b0, 19'h0, 5'd0, 2};
    tv[12] = '{1'b1, 32, 33, 1'b0, 1'b1, wd(0, 31, 30), 5'd1, 2};
    tv[13] = '{1'b0, 0, 0, 1'b1, 1'b1, wd(1, 33, 32), 5'd1, 2};
    tv[14] = '{1'b0, 0, 0, 1'b0, 1'b0, 19'h0, 5'd0, 3};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    for (int k = 0; k < 15; k++) begin
      step(tv[k].en, tv[k].i, tv[k].q, tv[k].done);
      chk($sformatf("vec%0d_valid", k), m_valid, tv[k].vld);
      chk($sformatf("vec%0d_level", k), level, tv[k].lvl);
      chk($sformatf("vec%0d_frame_cnt", k), frame_cnt, tv[k].fcnt);
      if (tv[k].vld) chk($sformatf("vec%0d_word", k), {m_last, m_data}, tv[k].word);
    end

    rst = 1; step(0, 0, 0, 0); rst = 0;
    m_ready = 0;
    for (int k = 1; k <= 20; k++) step(1, k, -k, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
`ifdef IQ_STREAM_TX_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 4);
`endif
    got.delete();
    m_ready = 1;
    wait_words(16);
    repeat (3) step(0, 0, 0, 0);
    chk("ovf_drain_count", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      chk($sformatf("ovf_word%0d", k + 1), got[k], wd(0, -(k + 1), k + 1));
    chk("ovf_frame_cnt", frame_cnt, 0);
    chk("ovf_sticky", overflow, 1);

    got.delete();
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("empty_done_words", got.size(), 0);
    step(1, 5, 6, 0);
    step(1, 7, 8, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    chk("dup_done_words", got.size(), 2);
    if (got.size() == 2) begin
      chk("dup_word1", got[0], wd(0, 6, 5));
      chk("dup_word2", got[1], wd(1, 8, 7));
    end
    chk("dup_frame_cnt", frame_cnt, 1);

    got.delete();
    stab_en = 1;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      if (c < 6) step(1, 50 + c, 60 + c, 0);
      else if (c == 6) step(0, 0, 0, 1);
      else step(0, 0, 0, 0);
    end
    m_ready = 1;
    repeat (3) step(0, 0, 0, 0);
    stab_en = 0;
    chk("stall_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      chk($sformatf("stall_word%0d", k + 1), got[k], wd(k == 5, 60 + k, 50 + k));
    chk("stall_frame_cnt", frame_cnt, 2);

    got.delete();
    m_ready = 0;
    for (int k = 0; k < 6; k++) step(1, 90 + k, 100 + k, 0);
    chk("mid_level", level, 5);
    rst = 1; step(0, 0, 0, 0); rst = 0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    m_ready = 1;
    step(1, 70, 71, 0);
    step(1, 72, 73, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    wait_words(2);
    repeat (3) step(0, 0, 0, 0);
    chk("post_rst_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst_word1", got[0], wd(0, 71, 70));
      chk("post_rst_word2", got[1], wd(1, 73, 72));
    end
    chk("post_rst_frame_cnt", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
